// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access stage and MEM/WB register.
// Runs sized loads/stores over a req/ack data bus, stalls the pipeline while
// the bus is busy, aborts on timeout and registers results for write-back.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_RegWrite,
  input  logic        ex_MemtoReg,
  input  logic        ex_MemRead,
  input  logic        ex_MemWrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_rd,
  output logic        access_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic [7:0] TMAX   = 8'(TIMEOUT_CYCLES - 1);

  logic [0:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_funct3;
  logic        r_regwrite;
  logic        r_memtoreg;
  logic [4:0]  r_rd;
  logic        r_wb_regwrite;
  logic        r_wb_memtoreg;
  logic [31:0] r_wb_mem_data;
  logic [31:0] r_wb_alu;
  logic [4:0]  r_wb_rd;
  logic        r_err;

  logic        w_access;
  logic        w_illegal;
  logic        w_legal;
  logic        w_timeout;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_wstrb;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  assign w_access  = ex_MemRead ^ ex_MemWrite;
  assign w_illegal = (ex_MemRead & ex_MemWrite) |
                     (w_access & ((ex_funct3 == 3'b011) | (ex_funct3 == 3'b110) |
                                  (ex_funct3 == 3'b111) |
                                  ((ex_funct3[1:0] == 2'b01) & ex_alu_result[0]) |
                                  ((ex_funct3[1:0] == 2'b10) & (ex_alu_result[1:0] != 2'b00))));
  assign w_legal   = w_access & ~w_illegal;
  assign w_timeout = (r_state == S_BUSY) & ~dmem_ack & (r_cnt == TMAX);

  // Stall while a legal access is launched or the bus is still outstanding;
  // the timeout cycle itself releases the pipeline.
  assign mem_stall = rst & (((r_state == S_IDLE) & w_legal) |
                            ((r_state == S_BUSY) & ~dmem_ack & ~w_timeout));

  // Store lane replication and byte enables
  always_comb begin
    w_st_wdata = ex_rs2_data;
    w_st_wstrb = 4'b0000;
    case (ex_funct3[1:0])
      2'b00: begin
        w_st_wdata = {4{ex_rs2_data[7:0]}};
        w_st_wstrb = 4'b0001 << ex_alu_result[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{ex_rs2_data[15:0]}};
        w_st_wstrb = ex_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_st_wdata = ex_rs2_data;
        w_st_wstrb = 4'b1111;
      end
    endcase
    if (!ex_MemWrite) w_st_wstrb = 4'b0000;
  end

  // Load lane selection and sign/zero extension from the latched address
  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_ld_byte = dmem_rdata[7:0];
      2'b01:   w_ld_byte = dmem_rdata[15:8];
      2'b10:   w_ld_byte = dmem_rdata[23:16];
      default: w_ld_byte = dmem_rdata[31:24];
    endcase
    w_ld_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b010:  w_ld_data = dmem_rdata;
      3'b100:  w_ld_data = {24'd0, w_ld_byte};
      3'b101:  w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = '0;
    endcase
  end

  // IDLE/BUSY controller, bus registers and MEM/WB register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_funct3      <= '0;
      r_regwrite    <= 1'b0;
      r_memtoreg    <= 1'b0;
      r_rd          <= '0;
      r_wb_regwrite <= 1'b0;
      r_wb_memtoreg <= 1'b0;
      r_wb_mem_data <= '0;
      r_wb_alu      <= '0;
      r_wb_rd       <= '0;
      r_err         <= 1'b0;
    end else begin
      // Default: bubble into MEM/WB, no error
      r_wb_regwrite <= 1'b0;
      r_wb_memtoreg <= 1'b0;
      r_wb_mem_data <= '0;
      r_wb_alu      <= '0;
      r_wb_rd       <= '0;
      r_err         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_legal) begin
            r_state    <= S_BUSY;
            r_cnt      <= '0;
            r_req      <= 1'b1;
            r_we       <= ex_MemWrite;
            r_addr     <= ex_alu_result;
            r_wdata    <= w_st_wdata;
            r_wstrb    <= w_st_wstrb;
            r_funct3   <= ex_funct3;
            r_regwrite <= ex_RegWrite;
            r_memtoreg <= ex_MemtoReg;
            r_rd       <= ex_rd;
          end else if (w_illegal) begin
            r_err <= 1'b1;
          end else begin
            r_wb_regwrite <= ex_RegWrite;
            r_wb_memtoreg <= ex_MemtoReg;
            r_wb_alu      <= ex_alu_result;
            r_wb_rd       <= ex_rd;
          end
        end
        default: begin
          if (dmem_ack) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_req         <= 1'b0;
            r_wb_regwrite <= r_regwrite;
            r_wb_memtoreg <= r_memtoreg;
            r_wb_mem_data <= r_we ? 32'd0 : w_ld_data;
            r_wb_alu      <= r_addr;
            r_wb_rd       <= r_rd;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign dmem_req      = r_req;
  assign dmem_we       = r_we;
  assign dmem_addr     = {r_addr[31:2], 2'b00};
  assign dmem_wdata    = r_wdata;
  assign dmem_wstrb    = r_wstrb;
  assign wb_RegWrite   = r_wb_regwrite;
  assign wb_MemtoReg   = r_wb_memtoreg;
  assign wb_mem_data   = r_wb_mem_data;
  assign wb_alu_result = r_wb_alu;
  assign wb_rd         = r_wb_rd;
  assign access_err    = r_err;

endmodule
